// File: rtl/scan_test_pkg.sv
// Shared types and helpers for the scan test controller.
package scan_test_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    COMPARE   = 3'd4
  } state_t;

  // Width-agnostic saturating increment; callers cast to/from their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    if (value >= max_value) begin
      return max_value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Chain image register: parallel load / MSB-first serial out, and serial in at the LSB
// so the first bit received ends up in the MSB after CHAIN_LEN shifts.
module scan_shift_reg #(
  parameter int CHAIN_LEN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [CHAIN_LEN-1:0] i_load_data,
  input  logic                 i_shift,
  input  logic                 i_serial_in,
  output logic                 o_serial_out,
  output logic                 o_last,
  output logic [CHAIN_LEN-1:0] o_data
);

  localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);

  logic [CHAIN_LEN-1:0] r_data;
  logic [BW-1:0]        r_cnt;
  logic [CHAIN_LEN-1:0] w_next;

  assign w_next       = (r_data << 1) | CHAIN_LEN'(i_serial_in);
  assign o_serial_out = r_data[CHAIN_LEN-1];
  assign o_last       = (r_cnt == LAST);
  assign o_data       = r_data;

  // Counter restarts whenever shifting pauses, so each shift burst counts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_data <= w_next;
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + BW'(1);
    end else begin
      r_cnt  <= '0;
    end
  end

endmodule

// File: rtl/scan_test_controller.sv
// Tester side of a mux-D scan protocol: shift in, capture, shift out, compare.
module scan_test_controller
  import scan_test_pkg::*;
#(
  parameter int CHAIN_LEN = 2,
  parameter int PI_WIDTH  = 1,
  parameter int PO_WIDTH  = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [CHAIN_LEN-1:0] i_chain_load,
  input  logic [PI_WIDTH-1:0]  i_pi_value,
  input  logic [CHAIN_LEN-1:0] i_exp_chain,
  input  logic [PO_WIDTH-1:0]  i_exp_po,
  output logic                 o_scan_en,
  output logic                 o_scan_in,
  output logic [PI_WIDTH-1:0]  o_dut_pi,
  input  logic                 i_scan_out,
  input  logic [PO_WIDTH-1:0]  i_dut_po,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [CHAIN_LEN-1:0] o_mismatch_chain,
  output logic [PO_WIDTH-1:0]  o_mismatch_po,
  output logic [CNT_WIDTH-1:0] o_pattern_cnt,
  output logic [CNT_WIDTH-1:0] o_fail_cnt
);

  localparam logic [31:0] CNT_MAX = 32'({CNT_WIDTH{1'b1}});

  state_t               r_state;
  logic [PI_WIDTH-1:0]  r_pi;
  logic [CHAIN_LEN-1:0] r_exp_chain;
  logic [PO_WIDTH-1:0]  r_exp_po;
  logic [PO_WIDTH-1:0]  r_po_sample;
  logic                 w_load;
  logic                 w_serial_in;
  logic                 w_serial_out;
  logic                 w_last;
  logic [CHAIN_LEN-1:0] w_captured;
  logic [CHAIN_LEN-1:0] w_mm_chain;
  logic [PO_WIDTH-1:0]  w_mm_po;
  logic                 w_pass;

  // Scan-side outputs are pure decodes of registered state.
  assign o_scan_en   = (r_state == SHIFT_IN) || (r_state == SHIFT_OUT);
  assign o_scan_in   = (r_state == SHIFT_IN) && w_serial_out;
  assign o_busy      = (r_state != IDLE);
  assign o_dut_pi    = r_pi;
  assign w_load      = (r_state == IDLE) && i_start;
  assign w_serial_in = (r_state == SHIFT_OUT) && i_scan_out;
  assign w_mm_chain  = w_captured ^ r_exp_chain;
  assign w_mm_po     = r_po_sample ^ r_exp_po;
  assign w_pass      = ~(|w_mm_chain) && ~(|w_mm_po);

  scan_shift_reg #(.CHAIN_LEN(CHAIN_LEN)) u_shift (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_data  (i_chain_load),
    .i_shift      (o_scan_en),
    .i_serial_in  (w_serial_in),
    .o_serial_out (w_serial_out),
    .o_last       (w_last),
    .o_data       (w_captured)
  );

  // Pattern sequencer with registered results and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_pi             <= '0;
      r_exp_chain      <= '0;
      r_exp_po         <= '0;
      r_po_sample      <= '0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_mismatch_chain <= '0;
      o_mismatch_po    <= '0;
      o_pattern_cnt    <= '0;
      o_fail_cnt       <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_pi        <= i_pi_value;
            r_exp_chain <= i_exp_chain;
            r_exp_po    <= i_exp_po;
            r_state     <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (w_last) r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_po_sample <= i_dut_po;
          r_state     <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          if (w_last) r_state <= COMPARE;
        end
        COMPARE: begin
          o_mismatch_chain <= w_mm_chain;
          o_mismatch_po    <= w_mm_po;
          o_pass           <= w_pass;
          o_done           <= 1'b1;
          o_pattern_cnt    <= o_pattern_cnt + CNT_WIDTH'(1);
          if (!w_pass) o_fail_cnt <= CNT_WIDTH'(sat_inc(32'(o_fail_cnt), CNT_MAX));
          r_state          <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
